// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and index constants for the integer register file
package regfile_pkg;
  typedef enum logic [1:0] {RF_IDLE, RF_CLEAR, RF_DONE} rf_state_e;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_IDX_ZERO = 0;
  localparam int RF_IDX_SP   = 2;
  localparam int RF_IDX_LAST = 31;
endpackage

// File: rtl/regfile_wr_decoder.sv
// regfile_wr_decoder: enabled 5-to-32 one-hot write-select decoder, x0 never selected
module regfile_wr_decoder import regfile_pkg::*; (
  input  logic [RF_ADDR_W-1:0]   sel_i,
  input  logic                   en_i,
  output logic [RF_NUM_REGS-1:0] onehot_o
);
  logic [RF_NUM_REGS-1:0] one_hot;
  assign one_hot  = {{(RF_NUM_REGS-1){1'b0}}, 1'b1} << sel_i;
  assign onehot_o = en_i ? {one_hot[RF_NUM_REGS-1:1], 1'b0} : '0;
endmodule

// File: rtl/regfile_bank.sv
// regfile_bank: x0..x31 register file, 1 write / 2 read ports, sequential clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_bank import regfile_pkg::*; #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_2000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [RF_ADDR_W-1:0] i_rs1_addr,
  input  logic [RF_ADDR_W-1:0] i_rs2_addr,
  input  logic [RF_ADDR_W-1:0] i_rd_addr,
  input  logic                 i_rd_wren,
  input  logic [DATA_W-1:0]    i_rd_data,
  input  logic                 i_clr_req,
  output logic [DATA_W-1:0]    o_rs1_data,
  output logic [DATA_W-1:0]    o_rs2_data,
  output logic                 o_clr_busy,
  output logic                 o_clr_done
);
  logic [DATA_W-1:0]      regs_q [RF_NUM_REGS];
  rf_state_e              state_q, state_d;
  logic [RF_ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic                   clearing, wr_ok, fwd1, fwd2;
  logic [RF_ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [RF_NUM_REGS-1:0] wr_sel;
  assign clearing = state_q == RF_CLEAR;
  assign wr_ok    = i_rd_wren && state_q == RF_IDLE;
  // The clear engine borrows the single write port while it walks x1..x31
  assign wr_addr  = clearing ? clr_ptr_q : i_rd_addr;
  assign wr_data  = !clearing ? i_rd_data :
                    (clr_ptr_q == RF_ADDR_W'(RF_IDX_SP)) ? SP_INIT : '0;
  regfile_wr_decoder u_dec (
    .sel_i    (wr_addr),
    .en_i     (clearing || wr_ok),
    .onehot_o (wr_sel)
  );
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      RF_IDLE: begin
        state_d   = i_clr_req ? RF_CLEAR : RF_IDLE;
        clr_ptr_d = RF_ADDR_W'(1);
      end
      RF_CLEAR: begin
        state_d   = (clr_ptr_q == RF_ADDR_W'(RF_IDX_LAST)) ? RF_DONE : RF_CLEAR;
        clr_ptr_d = (clr_ptr_q == RF_ADDR_W'(RF_IDX_LAST)) ? clr_ptr_q : clr_ptr_q + 1'b1;
      end
      RF_DONE: begin
        state_d   = RF_IDLE;
        clr_ptr_d = RF_ADDR_W'(1);
      end
      default: begin
        state_d   = RF_IDLE;
        clr_ptr_d = RF_ADDR_W'(1);
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= RF_IDLE;
      clr_ptr_q <= RF_ADDR_W'(1);
      for (int i = 0; i < RF_NUM_REGS; i++) regs_q[i] <= (i == RF_IDX_SP) ? SP_INIT : '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      for (int i = 0; i < RF_NUM_REGS; i++) if (wr_sel[i]) regs_q[i] <= wr_data;
    end
  end
`ifdef REGFILE_BYPASS_EN
  assign fwd1 = wr_ok && i_rd_addr != RF_ADDR_W'(RF_IDX_ZERO) && i_rd_addr == i_rs1_addr;
  assign fwd2 = wr_ok && i_rd_addr != RF_ADDR_W'(RF_IDX_ZERO) && i_rd_addr == i_rs2_addr;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  assign o_rs1_data = fwd1 ? i_rd_data :
                      (i_rs1_addr == RF_ADDR_W'(RF_IDX_ZERO)) ? '0 : regs_q[i_rs1_addr];
  assign o_rs2_data = fwd2 ? i_rd_data :
                      (i_rs2_addr == RF_ADDR_W'(RF_IDX_ZERO)) ? '0 : regs_q[i_rs2_addr];
  assign o_clr_busy = state_q != RF_IDLE;
  assign o_clr_done = state_q == RF_DONE;
endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: directed self-checking bench for regfile_bank
module tb_regfile_bank;
  localparam logic [31:0] SP = 32'h0000_2000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  rs1, rs2, rd;
  logic        wren, clr_req;
  logic [31:0] wdata, rs1_data, rs2_data;
  logic        busy, done;
  int          n_cmp = 0;
  int          n_err = 0;

  regfile_bank dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rs1_addr (rs1),
    .i_rs2_addr (rs2),
    .i_rd_addr  (rd),
    .i_rd_wren  (wren),
    .i_rd_data  (wdata),
    .i_clr_req  (clr_req),
    .o_rs1_data (rs1_data),
    .o_rs2_data (rs2_data),
    .o_clr_busy (busy),
    .o_clr_done (done)
  );

  initial forever #5 clk = ~clk;

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    rd = a; wdata = d; wren = 1'b1;
    @(posedge clk); #1;
    wren = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'hA5A5_0000 + 32'(i));
  endtask

  task automatic test_reset();
    #2;
    rs1 = 5'd2; rs2 = 5'd5; #1;
    n_cmp++; if (rs1_data !== SP) begin n_err++; $display("FAIL in_reset_x2 got %h want %h", rs1_data, SP); end
    n_cmp++; if (rs2_data !== 32'h0) begin n_err++; $display("FAIL in_reset_x5 got %h want 0", rs2_data); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL in_reset_flags got busy=%b done=%b want 0/0", busy, done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e1, e2;
      rs1 = 5'(i); rs2 = 5'(31 - i); #1;
      e1 = (i == 2) ? SP : 32'h0;
      e2 = (31 - i == 2) ? SP : 32'h0;
      n_cmp++; if (rs1_data !== e1) begin n_err++; $display("FAIL reset_rs1 x%0d got %h want %h", i, rs1_data, e1); end
      n_cmp++; if (rs2_data !== e2) begin n_err++; $display("FAIL reset_rs2 x%0d got %h want %h", 31 - i, rs2_data, e2); end
    end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_flags got busy=%b done=%b want 0/0", busy, done); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_x0();
    do_write(5'd5, 32'hDEAD_BEEF);
    do_write(5'd0, 32'hFFFF_FFFF);
    rs1 = 5'd5; rs2 = 5'd0; #1;
    n_cmp++; if (rs1_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL write_x5 got %h want deadbeef", rs1_data); end
    n_cmp++; if (rs2_data !== 32'h0) begin n_err++; $display("FAIL write_x0 got %h want 0", rs2_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    logic [31:0] same;
    rs1 = 5'd7; rs2 = 5'd0; rd = 5'd7; wdata = 32'h1234_5678; wren = 1'b1; #1;
`ifdef REGFILE_BYPASS_EN
    same = 32'h1234_5678;
`else
    same = 32'h0;
`endif
    n_cmp++; if (rs1_data !== same) begin n_err++; $display("FAIL same_cycle_x7 got %h want %h", rs1_data, same); end
    @(posedge clk); #1;
    wren = 1'b0; #1;
    n_cmp++; if (rs1_data !== 32'h1234_5678) begin n_err++; $display("FAIL next_cycle_x7 got %h want 12345678", rs1_data); end
    rd = 5'd0; wdata = 32'hFFFF_FFFF; wren = 1'b1; rs1 = 5'd0; #1;
    n_cmp++; if (rs1_data !== 32'h0) begin n_err++; $display("FAIL bypass_x0 got %h want 0", rs1_data); end
    @(posedge clk); #1;
    wren = 1'b0;
  endtask

  task automatic test_clear();
    int cyc, busy_cnt, done_cnt, done_at;
    fill_all();
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    cyc = 0; busy_cnt = 0; done_cnt = 0; done_at = 0;
    while (busy && cyc < 100) begin
      cyc++; busy_cnt++;
      if (done) begin done_cnt++; done_at = cyc; end
      if (cyc == 10) begin
        rs1 = 5'd9; rs2 = 5'd10; #1;
        n_cmp++; if (rs1_data !== 32'h0) begin n_err++; $display("FAIL partial_x9 got %h want 0", rs1_data); end
        n_cmp++; if (rs2_data !== 32'hA5A5_000A) begin n_err++; $display("FAIL partial_x10 got %h want a5a5000a", rs2_data); end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (busy_cnt !== 32) begin n_err++; $display("FAIL clear_busy_len got %0d want 32", busy_cnt); end
    n_cmp++; if (done_cnt !== 1 || done_at !== 32) begin n_err++; $display("FAIL clear_done got count=%0d at=%0d want 1 at 32", done_cnt, done_at); end
    for (int i = 1; i < 32; i++) begin
      logic [31:0] e;
      rs1 = 5'(i); #1;
      e = (i == 2) ? SP : 32'h0;
      n_cmp++; if (rs1_data !== e) begin n_err++; $display("FAIL cleared x%0d got %h want %h", i, rs1_data, e); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear_collision();
    int cyc, busy_cnt, done_cnt;
    do_write(5'd9, 32'h0000_0077);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    cyc = 0; busy_cnt = 0; done_cnt = 0;
    while (busy && cyc < 100) begin
      cyc++; busy_cnt++;
      if (done) done_cnt++;
      wren = 1'b0; clr_req = 1'b0;
      if (cyc == 12) begin rd = 5'd9; wdata = 32'h55; wren = 1'b1; clr_req = 1'b1; end
      if (cyc == 32) begin rd = 5'd3; wdata = 32'h33; wren = 1'b1; end
      @(posedge clk); #1;
    end
    wren = 1'b0; clr_req = 1'b0;
    n_cmp++; if (busy_cnt !== 32) begin n_err++; $display("FAIL collide_busy_len got %0d want 32", busy_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL collide_done got %0d want 1", done_cnt); end
    rs1 = 5'd9; rs2 = 5'd3; #1;
    n_cmp++; if (rs1_data !== 32'h0) begin n_err++; $display("FAIL collide_x9 got %h want 0", rs1_data); end
    n_cmp++; if (rs2_data !== 32'h0) begin n_err++; $display("FAIL done_write_x3 got %h want 0", rs2_data); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL collide_restart got busy=%b want 0", busy); end
    do_write(5'd3, 32'h0000_0033);
    rs2 = 5'd3; #1;
    n_cmp++; if (rs2_data !== 32'h33) begin n_err++; $display("FAIL post_clear_write got %h want 33", rs2_data); end
  endtask

  task automatic test_reset_mid_clear();
    int cyc, busy_cnt, done_cnt;
    do_write(5'd4, 32'h0000_0044);
    do_write(5'd2, 32'hBBBB_0000);
    do_write(5'd20, 32'h0000_2020);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL pre_reset_busy got %b want 1", busy); end
    rst_n = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mid_reset_flags got busy=%b done=%b want 0/0", busy, done); end
    rs1 = 5'd2; rs2 = 5'd20; #1;
    n_cmp++; if (rs1_data !== SP) begin n_err++; $display("FAIL mid_reset_x2 got %h want %h", rs1_data, SP); end
    n_cmp++; if (rs2_data !== 32'h0) begin n_err++; $display("FAIL mid_reset_x20 got %h want 0", rs2_data); end
    rs1 = 5'd4; #1;
    n_cmp++; if (rs1_data !== 32'h0) begin n_err++; $display("FAIL mid_reset_x4 got %h want 0", rs1_data); end
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (done) done_cnt++; end
    rst_n = 1'b1;
    for (int c = 0; c < 35; c++) begin @(posedge clk); #1; if (done || busy) done_cnt++; end
    n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL reset_no_done got %0d busy/done cycles want 0", done_cnt); end
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    cyc = 0; busy_cnt = 0; done_cnt = 0;
    while (busy && cyc < 100) begin
      cyc++; busy_cnt++;
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    n_cmp++; if (busy_cnt !== 32 || done_cnt !== 1) begin n_err++; $display("FAIL fresh_clear got busy=%0d done=%0d want 32/1", busy_cnt, done_cnt); end
  endtask

  initial begin
    rs1 = '0; rs2 = '0; rd = '0; wren = 1'b0; wdata = '0; clr_req = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    test_write_x0();
    test_bypass();
    test_clear();
    test_clear_collision();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
